// File: rtl/uart_irq_sched.sv
// uart_irq_sched: 16550-style interrupt scheduler for the UART core.
// Latches rx/tx/line-status events, runs the character-timeout counter,
// and presents a registered IIR code plus irq line to the register file.
// Optional modem-status interrupt source: define UART_IRQ_MSI_EN.
module uart_irq_sched #(
  parameter int FIFO_DEPTH     = 16,
  parameter int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int TO_CHARS       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [3:0]                irq_en_i,
  input  logic [1:0]                trg_level_i,
  input  logic [LOG_FIFO_DEPTH:0]   rx_elem_i,
  input  logic [LOG_FIFO_DEPTH:0]   tx_elem_i,
  input  logic                      rx_push_i,
  input  logic                      rx_pop_i,
  input  logic                      lsr_err_i,
  input  logic                      lsr_rd_i,
  input  logic                      iir_rd_i,
  input  logic                      thr_wr_i,
  input  logic                      msr_chg_i,
  input  logic                      msr_rd_i,
  input  logic                      baud_tick_i,
  input  logic [3:0]                frame_len_i,
  output logic [3:0]                iir_o,
  output logic                      irq_o
);

  localparam int CW = LOG_FIFO_DEPTH + 1;

  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_MSI  = 4'b0000;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  logic          rls_pend_q;
  logic          thre_pend_q;
  logic          tx_empty_q;
  logic          thre_en_q;
  logic [7:0]    to_cnt_q;
  logic [7:0]    to_limit;
  logic [CW-1:0] trig_cnt;
  logic          rda_pend;
  logic          cti_pend;
  logic          msi_pend;
  logic          tx_empty_now;
  logic          thre_set;
  logic          thre_clr;
  logic [3:0]    iir_next;

  // Map the rx trigger select onto a character count
  always_comb begin
    trig_cnt = CW'(1);
    case (trg_level_i)
      2'b00:   trig_cnt = CW'(1);
      2'b01:   trig_cnt = CW'(4);
      2'b10:   trig_cnt = CW'(8);
      default: trig_cnt = CW'(14);
    endcase
  end

  // RDA is a pure level: nothing to latch, it drops when the FIFO drains
  assign rda_pend = (rx_elem_i >= trig_cnt);

  // Timeout length in bit times; 8-bit product, zero frame length disables CTI
  assign to_limit = 8'(TO_CHARS) * {4'b0000, frame_len_i};
  assign cti_pend = (to_cnt_q == to_limit) && (to_limit != 8'd0) && (rx_elem_i != '0);

  // Character-timeout counter: restarts on any rx FIFO activity or when empty
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt_q <= 8'd0;
    end else if ((rx_elem_i == '0) || rx_push_i || rx_pop_i) begin
      to_cnt_q <= 8'd0;
    end else if (baud_tick_i && (to_cnt_q < to_limit)) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  // Receiver line status: an error arriving during the LSR read must not be lost
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rls_pend_q <= 1'b0;
    end else if (lsr_err_i) begin
      rls_pend_q <= 1'b1;
    end else if (lsr_rd_i) begin
      rls_pend_q <= 1'b0;
    end
  end

  // THRE sets on the tx FIFO emptying or on enabling THRE while already empty
  assign tx_empty_now = (tx_elem_i == '0);
  assign thre_set     = (tx_empty_now && !tx_empty_q) ||
                        (tx_empty_now && irq_en_i[1] && !thre_en_q);
  assign thre_clr     = thr_wr_i || (iir_rd_i && (iir_o == IIR_THRE));

  // THRE pending plus the edge-detect history it relies on; clears take precedence
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      thre_pend_q <= 1'b0;
      tx_empty_q  <= 1'b1;
      thre_en_q   <= 1'b0;
    end else begin
      tx_empty_q <= tx_empty_now;
      thre_en_q  <= irq_en_i[1];
      if (thre_clr) begin
        thre_pend_q <= 1'b0;
      end else if (thre_set) begin
        thre_pend_q <= 1'b1;
      end
    end
  end

`ifdef UART_IRQ_MSI_EN
  logic msi_pend_q;

  // Modem status delta latch; a change during the MSR read keeps the flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      msi_pend_q <= 1'b0;
    end else if (msr_chg_i) begin
      msi_pend_q <= 1'b1;
    end else if (msr_rd_i) begin
      msi_pend_q <= 1'b0;
    end
  end

  assign msi_pend = msi_pend_q;
`else
  logic unused_msi;
  assign unused_msi = msr_chg_i ^ msr_rd_i;
  assign msi_pend   = 1'b0;
`endif

  // Fixed-priority arbitration over the enabled sources
  always_comb begin
    iir_next = IIR_NONE;
    if (irq_en_i[2] && rls_pend_q) begin
      iir_next = IIR_RLS;
    end else if (irq_en_i[0] && rda_pend) begin
      iir_next = IIR_RDA;
    end else if (irq_en_i[0] && cti_pend) begin
      iir_next = IIR_CTI;
    end else if (irq_en_i[1] && thre_pend_q) begin
      iir_next = IIR_THRE;
    end else if (irq_en_i[3] && msi_pend) begin
      iir_next = IIR_MSI;
    end
  end

  // Register the identification code and request line for the register file
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      iir_o <= IIR_NONE;
      irq_o <= 1'b0;
    end else begin
      iir_o <= iir_next;
      irq_o <= (iir_next != IIR_NONE);
    end
  end

endmodule

// File: tb/tb_uart_irq_sched.sv
// Directed testbench for uart_irq_sched with hand-computed IIR/irq values.
// Build with +define+UART_IRQ_MSI_EN to exercise the modem status source.
module tb_uart_irq_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_en;
  logic [1:0] trg_level;
  logic [4:0] rx_elem;
  logic [4:0] tx_elem;
  logic       rx_push, rx_pop, lsr_err, lsr_rd, iir_rd, thr_wr;
  logic       msr_chg, msr_rd, baud_tick;
  logic [3:0] frame_len;
  logic [3:0] iir;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_irq_sched dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .irq_en_i    (irq_en),
    .trg_level_i (trg_level),
    .rx_elem_i   (rx_elem),
    .tx_elem_i   (tx_elem),
    .rx_push_i   (rx_push),
    .rx_pop_i    (rx_pop),
    .lsr_err_i   (lsr_err),
    .lsr_rd_i    (lsr_rd),
    .iir_rd_i    (iir_rd),
    .thr_wr_i    (thr_wr),
    .msr_chg_i   (msr_chg),
    .msr_rd_i    (msr_rd),
    .baud_tick_i (baud_tick),
    .frame_len_i (frame_len),
    .iir_o       (iir),
    .irq_o       (irq)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Advance n clock edges, then settle 1 ns past the edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_iir(input string tag, input logic [3:0] exp_iir);
    chk({tag, ".iir"}, iir, exp_iir);
    chk({tag, ".irq"}, {3'b000, irq}, {3'b000, exp_iir != 4'b0001});
  endtask

  initial begin
    rst_n = 1'b0; irq_en = 4'b0000; trg_level = 2'b00;
    rx_elem = 5'd0; tx_elem = 5'd0;
    rx_push = 0; rx_pop = 0; lsr_err = 0; lsr_rd = 0; iir_rd = 0; thr_wr = 0;
    msr_chg = 0; msr_rd = 0; baud_tick = 0; frame_len = 4'd0;

    // Reset values
    tick(2);
    chk_iir("reset", 4'b0001);
    rst_n = 1'b1;
    tick(1);
    chk_iir("post_reset", 4'b0001);

    // THRE via enable rising with tx empty: flag at edge 1, IIR at edge 2
    irq_en = 4'b0010;
    tick(1);
    chk_iir("thre_en_lat1", 4'b0001);
    tick(1);
    chk_iir("thre_en_lat2", 4'b0010);
    // IIR read while reporting THRE clears it
    iir_rd = 1; tick(1); iir_rd = 0;
    tick(1);
    chk_iir("thre_iir_rd", 4'b0001);
    irq_en = 4'b0000;

    // RDA with trigger 4
    trg_level = 2'b01; irq_en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      rx_push = 1; tick(1); rx_push = 0; rx_elem = rx_elem + 5'd1;
      if (i == 2) begin
        tick(1);
        chk_iir("rda_below_trig", 4'b0001);
      end
    end
    tick(1);
    chk_iir("rda_at_trig", 4'b0100);
    rx_pop = 1; tick(1); rx_pop = 0; rx_elem = 5'd3;
    tick(1);
    chk_iir("rda_drained", 4'b0001);
    rx_pop = 1; tick(1); rx_pop = 0; rx_elem = 5'd0;
    tick(1);

    // CTI: frame_len 10 -> limit 40 bit times
    frame_len = 4'd10;
    rx_push = 1; tick(1); rx_push = 0; rx_elem = 5'd1;
    baud_tick = 1; tick(39); baud_tick = 0;
    tick(1);
    chk_iir("cti_39_ticks", 4'b0001);
    baud_tick = 1; tick(1); baud_tick = 0;
    tick(1);
    chk_iir("cti_40_ticks", 4'b1100);
    tick(3);
    chk_iir("cti_saturated", 4'b1100);
    rx_pop = 1; tick(1); rx_pop = 0;
    tick(1);
    chk_iir("cti_pop", 4'b0001);
    // Push just before expiry restarts the timeout
    baud_tick = 1; tick(39); baud_tick = 0;
    rx_push = 1; tick(1); rx_push = 0;
    baud_tick = 1; tick(1); baud_tick = 0;
    tick(1);
    chk_iir("cti_push_restart", 4'b0001);
    frame_len = 4'd0; rx_elem = 5'd0;
    tick(1);

    // RLS over RDA (irq_en rising bit1 with tx empty also latches THRE)
    trg_level = 2'b00; irq_en = 4'b0111; rx_elem = 5'd1;
    lsr_err = 1; tick(1); lsr_err = 0;
    tick(1);
    chk_iir("rls_over_rda", 4'b0110);
    lsr_rd = 1; tick(1); lsr_rd = 0;
    tick(1);
    chk_iir("rls_read", 4'b0100);
    lsr_err = 1; lsr_rd = 1; tick(1); lsr_err = 0; lsr_rd = 0;
    tick(1);
    chk_iir("rls_set_wins", 4'b0110);
    lsr_rd = 1; tick(1); lsr_rd = 0;
    rx_elem = 5'd0;
    tick(1);
    chk_iir("thre_lowest", 4'b0010);
    thr_wr = 1; tick(1); thr_wr = 0;
    tick(1);
    chk_iir("thre_thr_wr", 4'b0001);

    // THRE from the tx FIFO emptying
    irq_en = 4'b0010; tx_elem = 5'd1;
    tick(1);
    tx_elem = 5'd0;
    tick(2);
    chk_iir("thre_tx_drain", 4'b0010);
    // Drain coinciding with a THR write: clear wins
    tx_elem = 5'd1; tick(1);
    tx_elem = 5'd0; thr_wr = 1; tick(1); thr_wr = 0;
    tick(1);
    chk_iir("thre_clr_wins", 4'b0001);
    irq_en = 4'b0000; tick(2);
    irq_en = 4'b0010; tick(2);
    chk_iir("thre_reenable", 4'b0010);
    thr_wr = 1; tick(1); thr_wr = 0;
    irq_en = 4'b0000;
    tick(1);

    // Modem status source
    irq_en = 4'b1000;
    msr_chg = 1; tick(1); msr_chg = 0;
    tick(1);
`ifdef UART_IRQ_MSI_EN
    chk_iir("msi_set", 4'b0000);
`else
    chk_iir("msi_absent", 4'b0001);
`endif
    msr_rd = 1; tick(1); msr_rd = 0;
    tick(1);
    chk_iir("msi_read", 4'b0001);

    // Masking keeps the latched RLS flag
    irq_en = 4'b0000;
    lsr_err = 1; tick(1); lsr_err = 0;
    tick(1);
    chk_iir("rls_masked", 4'b0001);
    irq_en = 4'b0100;
    tick(1);
    chk_iir("rls_unmasked", 4'b0110);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk_iir("async_reset", 4'b0001);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk_iir("reset_cleared_rls", 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
